// File: rtl/lr35902_pkg.sv
// Shared types and constants for the LR35902 bus read-return path.
//   region_t : target region selected by the address decoder (REG_NONE = unmapped)
//   state_t  : read-return FSM states
//   OPEN_BUS_DEFAULT : byte returned for unmapped or locked reads
package lr35902_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_BROM,
    REG_ROM,
    REG_XRAM,
    REG_VRAM,
    REG_WRAM,
    REG_OAM,
    REG_IO
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hff;
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/lr35902_region_enc.sv
// Combinational priority encoder from the decoder's chip selects to a region.
// Priority when several selects are high: brom > rom > xram > vram > oam > io > wram.
// Ports:
//   cs_brom .. cs_io : chip selects from the address decoder
//   region           : encoded region, REG_NONE when no select is high
module lr35902_region_enc
  import lr35902_pkg::*;
(
  input  logic    cs_brom,
  input  logic    cs_rom,
  input  logic    cs_xram,
  input  logic    cs_vram,
  input  logic    cs_wram,
  input  logic    cs_oam,
  input  logic    cs_io,
  output region_t region
);

  always_comb begin
    region = REG_NONE;
    if (cs_brom)      region = REG_BROM;
    else if (cs_rom)  region = REG_ROM;
    else if (cs_xram) region = REG_XRAM;
    else if (cs_vram) region = REG_VRAM;
    else if (cs_oam)  region = REG_OAM;
    else if (cs_io)   region = REG_IO;
    else if (cs_wram) region = REG_WRAM;
  end

endmodule

// File: rtl/lr35902_rdata_return.sv
// Read-data return path: applies per-region wait states, steers the selected
// target's byte to the CPU, and substitutes OPEN_BUS for unmapped or
// PPU-locked reads.
// Ports:
//   clk, reset_n        : system clock, synchronous active-low reset
//   rd_stb              : one-cycle read request, cs_* valid in the same cycle
//   cs_* / d_*          : per-target chip select and read data
//   vram_lock, oam_lock : PPU/DMA ownership of VRAM / OAM
//   rdata               : returned byte, held until the next rd_ack
//   rd_ack              : one-cycle pulse, rdata valid from this cycle
//   busy                : wait states in progress, rd_stb ignored
//
// state   | meaning
// IDLE    | no transaction; accepts rd_stb
// WAIT    | counting down wait states; busy=1
// DONE    | ack cycle; rdata valid, busy=0, accepts a back-to-back rd_stb
//
// Data and locks are captured on the edge that enters DONE, i.e. during the
// final wait cycle (the rd_stb cycle itself when the region has no wait states).
module lr35902_rdata_return
  import lr35902_pkg::*;
#(
  parameter int unsigned WS_BROM  = 0,
  parameter int unsigned WS_ROM   = 1,
  parameter int unsigned WS_XRAM  = 1,
  parameter int unsigned WS_VRAM  = 0,
  parameter int unsigned WS_WRAM  = 0,
  parameter int unsigned WS_OAM   = 0,
  parameter int unsigned WS_IO    = 0,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_stb,
  input  logic       cs_brom,
  input  logic       cs_rom,
  input  logic       cs_xram,
  input  logic       cs_vram,
  input  logic       cs_wram,
  input  logic       cs_oam,
  input  logic       cs_io,
  input  logic [7:0] d_brom,
  input  logic [7:0] d_rom,
  input  logic [7:0] d_xram,
  input  logic [7:0] d_vram,
  input  logic [7:0] d_wram,
  input  logic [7:0] d_oam,
  input  logic [7:0] d_io,
  input  logic       vram_lock,
  input  logic       oam_lock,
  output logic [7:0] rdata,
  output logic       rd_ack,
  output logic       busy
);

  if (WS_BROM > 7 || WS_ROM > 7 || WS_XRAM > 7 || WS_VRAM > 7 ||
      WS_WRAM > 7 || WS_OAM > 7 || WS_IO > 7) begin : g_ws_range
    $error("lr35902_rdata_return: wait-state parameters must be 0..7");
  end

  localparam logic [CNT_W-1:0] WS_BROM_C = WS_BROM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_ROM_C  = WS_ROM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_XRAM_C = WS_XRAM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_VRAM_C = WS_VRAM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_WRAM_C = WS_WRAM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_OAM_C  = WS_OAM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WS_IO_C   = WS_IO[CNT_W-1:0];

  state_t           state_q, state_d;
  region_t          region_q, region_d;
  region_t          enc_region;
  region_t          cap_region;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ws_sel;
  logic [7:0]       rdata_q;
  logic [7:0]       sel_data;
  logic             capture;
  logic             accept;

  lr35902_region_enc u_region_enc (
    .cs_brom (cs_brom),
    .cs_rom  (cs_rom),
    .cs_xram (cs_xram),
    .cs_vram (cs_vram),
    .cs_wram (cs_wram),
    .cs_oam  (cs_oam),
    .cs_io   (cs_io),
    .region  (enc_region)
  );

  always_comb begin
    ws_sel = '0;
    case (enc_region)
      REG_BROM: ws_sel = WS_BROM_C;
      REG_ROM:  ws_sel = WS_ROM_C;
      REG_XRAM: ws_sel = WS_XRAM_C;
      REG_VRAM: ws_sel = WS_VRAM_C;
      REG_WRAM: ws_sel = WS_WRAM_C;
      REG_OAM:  ws_sel = WS_OAM_C;
      REG_IO:   ws_sel = WS_IO_C;
      default:  ws_sel = '0;
    endcase
  end

  // A zero-wait read captures in its own rd_stb cycle, before region_q is loaded.
  assign accept     = rd_stb && (state_q != ST_WAIT);
  assign cap_region = accept ? enc_region : region_q;

  always_comb begin
    sel_data = OPEN_BUS;
    case (cap_region)
      REG_BROM: sel_data = d_brom;
      REG_ROM:  sel_data = d_rom;
      REG_XRAM: sel_data = d_xram;
      REG_VRAM: sel_data = vram_lock ? OPEN_BUS : d_vram;
      REG_WRAM: sel_data = d_wram;
      REG_OAM:  sel_data = oam_lock ? OPEN_BUS : d_oam;
      REG_IO:   sel_data = d_io;
      default:  sel_data = OPEN_BUS;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (rd_stb) begin
          region_d = enc_region;
          cnt_d    = ws_sel;
          if (ws_sel == '0) begin
            state_d = ST_DONE;
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      region_q <= REG_NONE;
      cnt_q    <= '0;
      rdata_q  <= OPEN_BUS;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      if (capture) rdata_q <= sel_data;
    end
  end

  assign rdata  = rdata_q;
  assign rd_ack = (state_q == ST_DONE);
  assign busy   = (state_q == ST_WAIT);

endmodule
